// File: rtl/processor_scheduler.sv
// Time-shares one memory port, GPU and interrupt controller between three
// processors; one owner runs at a time and hand-off waits for interrupt end.
module processor_scheduler #(
   parameter int DRAIN_TIMEOUT = 255,
   parameter int BOOT_PROC     = 0
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [2:0]  P_SWITCH_REQUEST,
   input  logic [2:0]  P_FATAL_ERROR,
   input  logic [2:0]  P_MEM_ENABLE,
   input  logic [2:0]  P_MEM_WRITE,
   input  logic [47:0] P_MEM_ADDR,
   input  logic [47:0] P_MEM_DATA_W,
   input  logic [2:0]  P_GPU_DRAW,
   input  logic [2:0]  P_INT_IACK,
   input  logic [2:0]  P_INT_IEND,
   output logic        MEM_ENABLE,
   output logic        MEM_WRITE,
   output logic [15:0] MEM_ADDR,
   output logic [15:0] MEM_DATA_W,
   input  logic        GPU_READY,
   output logic        GPU_DRAW,
   input  logic [1:0]  INT_IRQ,
   output logic        INT_IACK,
   output logic        INT_IEND,
   output logic [2:0]  P_ENABLE,
   output logic [2:0]  P_GPU_READY,
   output logic [5:0]  P_IRQ,
   output logic [1:0]  ACTIVE,
   output logic        HALTED
);

   // Out-of-range boot index falls back to processor 0.
   localparam logic [1:0] BOOT_IDX =
      (BOOT_PROC >= 1 && BOOT_PROC <= 2) ? 2'(BOOT_PROC) : 2'd0;
   localparam logic [7:0] TIMEOUT = 8'(DRAIN_TIMEOUT);

   typedef enum logic [2:0] {
      S_BOOT,
      S_RUN,
      S_DRAIN,
      S_HANDOFF,
      S_HALT
   } state_t;

   state_t      state;
   logic [1:0]  active_q;
   logic        in_service;
   logic [7:0]  drain_cnt;
   logic        reset_seen;

   logic        run;
   logic        drain;
   logic [2:0]  own;
   logic        iend_sel;
   logic        forced_iend;

   assign run   = !RESET && (state == S_RUN);
   assign drain = !RESET && (state == S_DRAIN);
   assign own   = 3'(3'b001 << active_q);

   assign iend_sel    = |(P_INT_IEND & own);
   assign forced_iend = drain && in_service && !iend_sel &&
                        (drain_cnt == TIMEOUT);

   assign MEM_ENABLE = run && |(P_MEM_ENABLE & own);
   assign MEM_WRITE  = run && |(P_MEM_WRITE & own);
   assign GPU_DRAW   = run && |(P_GPU_DRAW & own);
   assign INT_IACK   = run && |(P_INT_IACK & own);
   assign INT_IEND   = ((run || drain) && iend_sel) || forced_iend;

   assign P_ENABLE    = run ? own : 3'b000;
   assign P_GPU_READY = P_ENABLE & {3{GPU_READY}};
   assign ACTIVE      = active_q;
   assign HALTED      = (state == S_HALT);

   always_comb begin
      MEM_ADDR   = P_MEM_ADDR[15:0];
      MEM_DATA_W = P_MEM_DATA_W[15:0];
      unique case (active_q)
         2'd1: begin
            MEM_ADDR   = P_MEM_ADDR[31:16];
            MEM_DATA_W = P_MEM_DATA_W[31:16];
         end
         2'd2: begin
            MEM_ADDR   = P_MEM_ADDR[47:32];
            MEM_DATA_W = P_MEM_DATA_W[47:32];
         end
         default: begin
            MEM_ADDR   = P_MEM_ADDR[15:0];
            MEM_DATA_W = P_MEM_DATA_W[15:0];
         end
      endcase
   end

   always_comb begin
      P_IRQ = 6'b11_11_11;
      for (int i = 0; i < 3; i++) begin
         if (P_ENABLE[i]) P_IRQ[2*i +: 2] = INT_IRQ;
      end
   end

   // BOOT lingers one extra cycle after reset release so RUN starts
   // two edges after RESET falls.
   always_ff @(posedge CLK) begin
      reset_seen <= RESET;
      if (RESET) begin
         state      <= S_BOOT;
         active_q   <= BOOT_IDX;
         in_service <= 1'b0;
         drain_cnt  <= 8'd0;
      end else begin
         unique case (state)
            S_BOOT: begin
               active_q   <= BOOT_IDX;
               in_service <= 1'b0;
               drain_cnt  <= 8'd0;
               if (!reset_seen) state <= S_RUN;
            end
            S_RUN: begin
               drain_cnt <= 8'd0;
               if (INT_IEND)      in_service <= 1'b0;
               else if (INT_IACK) in_service <= 1'b1;
               if (|(P_FATAL_ERROR & own))         state <= S_HALT;
               else if (|(P_SWITCH_REQUEST & own)) state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (!in_service || INT_IEND) begin
                  in_service <= 1'b0;
                  state      <= S_HANDOFF;
               end else begin
                  drain_cnt <= drain_cnt + 8'd1;
               end
            end
            S_HANDOFF: begin
               active_q <= (active_q == 2'd2) ? 2'd0 : active_q + 2'd1;
               state    <= S_RUN;
            end
            S_HALT: state <= S_HALT;
            default: state <= S_BOOT;
         endcase
      end
   end

endmodule
